// File: rtl/gpr_wr_arb_pkg.sv
// Shared types and parameters for the GPR write-port arbiter and its helpers.
package gpr_wr_arb_pkg;

  localparam int NUM_LR     = 2;
  localparam int STARVE_MAX = 4;
  localparam int GPR_AW     = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic              wr;
    logic [GPR_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } gpr_wr_req_t;

  // Index width that stays legal for a single requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpr_wr_arb_if.sv
// Write Back / long-latency / register-file bundle around the GPR write arbiter.
interface gpr_wr_arb_if #(
  parameter int NUM_LR = 2,
  parameter int GPR_AW = 5,
  parameter int XLEN   = 32
) ();

  logic                     cpu_halt;
  logic                     wb_wr;
  logic [GPR_AW-1:0]        wb_addr;
  logic [XLEN-1:0]          wb_data;
  logic                     wb_hold;
  logic [NUM_LR-1:0]        lr_valid;
  logic [NUM_LR*GPR_AW-1:0] lr_addr;
  logic [NUM_LR*XLEN-1:0]   lr_data;
  logic [NUM_LR-1:0]        lr_rdy;
  logic                     gpr_wr;
  logic [GPR_AW-1:0]        gpr_addr;
  logic [XLEN-1:0]          gpr_data;

  modport master (
    output cpu_halt, wb_wr, wb_addr, wb_data, lr_valid, lr_addr, lr_data,
    input  wb_hold, lr_rdy, gpr_wr, gpr_addr, gpr_data
  );

  modport slave (
    input  cpu_halt, wb_wr, wb_addr, wb_data, lr_valid, lr_addr, lr_data,
    output wb_hold, lr_rdy, gpr_wr, gpr_addr, gpr_data
  );

endinterface

// File: rtl/gpr_wr_arb_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first request at or after ptr.
module rr_pick
  import gpr_wr_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/gpr_wr_arb.sv
// Arbitrates the single GPR write port between Write Back (priority) and
// out-of-order long-latency units, with a one-cycle anti-starvation hold.
module gpr_wr_arb
  import gpr_wr_arb_pkg::*;
#(
  parameter int NUM_LR     = gpr_wr_arb_pkg::NUM_LR,
  parameter int STARVE_MAX = gpr_wr_arb_pkg::STARVE_MAX,
  parameter int GPR_AW     = gpr_wr_arb_pkg::GPR_AW,
  parameter int XLEN       = gpr_wr_arb_pkg::XLEN
) (
  input  logic           clk_in,
  input  logic           reset_in,
  gpr_wr_arb_if.slave    bus
);

  localparam int PTR_W = ptr_w(NUM_LR);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  gpr_wr_req_t       lr_req [NUM_LR];
  gpr_wr_req_t       out_q, out_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [NUM_LR-1:0] pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              wb_hold, grant_en, wb_gnt, lr_gnt;

  generate
    for (genvar gi = 0; gi < NUM_LR; gi++) begin : g_lr_req
      assign lr_req[gi] = '{wr:   bus.lr_valid[gi],
                            addr: bus.lr_addr[gi*GPR_AW +: GPR_AW],
                            data: bus.lr_data[gi*XLEN +: XLEN]};
    end
  endgenerate

  rr_pick #(.N(NUM_LR), .PW(PTR_W)) u_rr_pick (
    .req     (bus.lr_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // Hold comes from registered state only, so it never loops back through wb_wr.
  assign wb_hold  = (starve_cnt_q == CNT_W'(STARVE_MAX)) && !bus.cpu_halt;
  assign grant_en = !reset_in && !bus.cpu_halt;
  assign wb_gnt   = grant_en && !wb_hold && bus.wb_wr;
  assign lr_gnt   = grant_en && !wb_gnt && (|bus.lr_valid);

  assign bus.wb_hold = wb_hold;
  assign bus.lr_rdy  = lr_gnt ? pick_gnt : '0;

  always_comb begin
    out_d    = out_q;
    out_d.wr = 1'b0;
    if (wb_gnt) begin
      out_d.wr   = (bus.wb_addr != '0);
      out_d.addr = bus.wb_addr;
      out_d.data = bus.wb_data;
    end else if (lr_gnt) begin
      out_d.wr   = lr_req[pick_idx].wr && (lr_req[pick_idx].addr != '0);
      out_d.addr = lr_req[pick_idx].addr;
      out_d.data = lr_req[pick_idx].data;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (lr_gnt) begin
      ptr_d = (pick_idx == PTR_W'(NUM_LR - 1)) ? '0 : pick_idx + PTR_W'(1);
    end
  end

  // Halt freezes the counter even if the units go quiet meanwhile.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.cpu_halt) begin
      if (lr_gnt || (bus.lr_valid == '0)) begin
        starve_cnt_d = '0;
      end else if (wb_gnt && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      out_q        <= '0;
      ptr_q        <= '0;
      starve_cnt_q <= '0;
    end else begin
      out_q        <= out_d;
      ptr_q        <= ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.gpr_wr   = out_q.wr;
  assign bus.gpr_addr = out_q.addr;
  assign bus.gpr_data = out_q.data;

endmodule

// File: tb/tb_gpr_wr_arb.sv
// Directed bench for gpr_wr_arb: stimulus pushes expected writes, a negedge monitor pops them.
module tb_gpr_wr_arb;

  logic clk = 1'b0;
  logic rst;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  gpr_wr_arb_if #(.NUM_LR(2), .GPR_AW(5), .XLEN(32)) bus ();

  gpr_wr_arb dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lr(input logic [1:0] v, input logic [4:0] a1, input logic [4:0] a0,
                        input logic [31:0] d1, input logic [31:0] d0);
    bus.lr_valid = v;
    bus.lr_addr  = {a1, a0};
    bus.lr_data  = {d1, d0};
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.gpr_wr !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {63'd0, bus.gpr_wr}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("gpr write x%0d = %08h (expected x%0d = %08h)", bus.gpr_addr, bus.gpr_data, e.a, e.d);
        chk("wr_addr", {59'd0, bus.gpr_addr}, {59'd0, e.a});
        chk("wr_data", {32'd0, bus.gpr_data}, {32'd0, e.d});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.cpu_halt = 1'b0;
    bus.wb_wr    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    set_lr(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gpr_wr", {63'd0, bus.gpr_wr}, 64'd0);
    chk("rst_gpr_addr", {59'd0, bus.gpr_addr}, 64'd0);
    chk("rst_gpr_data", {32'd0, bus.gpr_data}, 64'd0);
    chk("rst_wb_hold", {63'd0, bus.wb_hold}, 64'd0);
    chk("rst_lr_rdy", {62'd0, bus.lr_rdy}, 64'd0);
    tick(); rst = 1'b0;

    // Write Back only
    tick(); bus.wb_wr = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF; #1;
    chk("wb_only_hold", {63'd0, bus.wb_hold}, 64'd0);
    chk("wb_only_rdy", {62'd0, bus.lr_rdy}, 64'd0);
    push(5'd5, 32'hDEADBEEF);
    tick(); bus.wb_wr = 1'b0; #1;
    chk("wb_only_hold_after", {63'd0, bus.wb_hold}, 64'd0);

    // Long-latency only, round-robin with wrap
    tick(); set_lr(2'b11, 5'd7, 5'd3, 32'h7777_0007, 32'h3333_0003); #1;
    chk("lr_rr_first", {62'd0, bus.lr_rdy}, 64'd1);
    push(5'd3, 32'h3333_0003);
    tick(); bus.lr_valid = 2'b10; #1;
    chk("lr_rr_second", {62'd0, bus.lr_rdy}, 64'd2);
    push(5'd7, 32'h7777_0007);
    tick(); set_lr(2'b11, 5'd7, 5'd3, 32'h7777_0007, 32'h3333_0033); #1;
    chk("lr_rr_wrap", {62'd0, bus.lr_rdy}, 64'd1);
    push(5'd3, 32'h3333_0033);
    tick(); bus.lr_valid = 2'b00;

    // Starvation: four Write Back wins, then a one-cycle hold for unit 1
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.wb_wr = 1'b1; bus.wb_addr = 5'(10 + i); bus.wb_data = 32'h1000 + i;
      set_lr(2'b10, 5'd9, 5'd0, 32'hAAAA_0009, 32'd0); #1;
      chk("starve_wb_hold", {63'd0, bus.wb_hold}, 64'd0);
      chk("starve_wb_rdy", {62'd0, bus.lr_rdy}, 64'd0);
      push(5'(10 + i), 32'h1000 + i);
    end
    tick(); bus.wb_addr = 5'd20; bus.wb_data = 32'h2020; #1;
    chk("starve_hold_on", {63'd0, bus.wb_hold}, 64'd1);
    chk("starve_lr_gnt", {62'd0, bus.lr_rdy}, 64'd2);
    push(5'd9, 32'hAAAA_0009);
    tick(); bus.lr_valid = 2'b00; #1;
    chk("starve_hold_off", {63'd0, bus.wb_hold}, 64'd0);
    chk("starve_rdy_off", {62'd0, bus.lr_rdy}, 64'd0);
    push(5'd20, 32'h2020);
    tick(); bus.wb_wr = 1'b0;

    // x0 write: handshake completes, no register-file write
    tick(); set_lr(2'b01, 5'd0, 5'd0, 32'd0, 32'h0BAD); #1;
    chk("x0_rdy", {62'd0, bus.lr_rdy}, 64'd1);
    tick(); bus.lr_valid = 2'b00;
    @(negedge clk);
    chk("x0_gpr_wr", {63'd0, bus.gpr_wr}, 64'd0);

    // Halt: counter reaches 2, freezes for 3 halt cycles, then 2 more wins trigger hold
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.wb_wr = 1'b1; bus.wb_addr = 5'(14 + i); bus.wb_data = 32'h5000 + i;
      set_lr(2'b11, 5'd13, 5'd12, 32'hC1, 32'hC0); #1;
      chk("pre_halt_rdy", {62'd0, bus.lr_rdy}, 64'd0);
      push(5'(14 + i), 32'h5000 + i);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); bus.cpu_halt = 1'b1; #1;
      chk("halt_rdy", {62'd0, bus.lr_rdy}, 64'd0);
      chk("halt_hold", {63'd0, bus.wb_hold}, 64'd0);
      if (i > 0) begin
        @(negedge clk);
        chk("halt_gpr_wr", {63'd0, bus.gpr_wr}, 64'd0);
      end
    end
    tick(); bus.cpu_halt = 1'b0; bus.wb_addr = 5'd16; bus.wb_data = 32'h5002; #1;
    chk("resume_hold", {63'd0, bus.wb_hold}, 64'd0);
    chk("resume_rdy", {62'd0, bus.lr_rdy}, 64'd0);
    push(5'd16, 32'h5002);
    @(negedge clk);
    chk("resume_gpr_wr_idle", {63'd0, bus.gpr_wr}, 64'd0);
    tick(); bus.wb_addr = 5'd17; bus.wb_data = 32'h5003; #1;
    chk("resume_hold2", {63'd0, bus.wb_hold}, 64'd0);
    push(5'd17, 32'h5003);
    tick(); bus.wb_addr = 5'd18; bus.wb_data = 32'h5004; #1;
    chk("resume_hold_on", {63'd0, bus.wb_hold}, 64'd1);
    chk("resume_lr_gnt", {62'd0, bus.lr_rdy}, 64'd2);
    push(5'd13, 32'hC1);
    tick(); bus.lr_valid = 2'b01; #1;
    chk("resume_hold_off", {63'd0, bus.wb_hold}, 64'd0);
    push(5'd18, 32'h5004);

    // Reset mid-stream: pointer at 1, counter at 3, a write in flight
    tick(); bus.wb_wr = 1'b0; #1;
    chk("pre_rst_lr_gnt", {62'd0, bus.lr_rdy}, 64'd1);
    push(5'd12, 32'hC0);
    for (int i = 0; i < 3; i++) begin
      tick(); bus.wb_wr = 1'b1; bus.wb_addr = 5'(21 + i); bus.wb_data = 32'h6000 + i; #1;
      chk("pre_rst_hold", {63'd0, bus.wb_hold}, 64'd0);
      push(5'(21 + i), 32'h6000 + i);
    end
    tick(); rst = 1'b1; bus.wb_addr = 5'd24; bus.wb_data = 32'h6003; #1;
    chk("in_rst_rdy", {62'd0, bus.lr_rdy}, 64'd0);
    tick(); rst = 1'b0; bus.wb_addr = 5'd25; bus.wb_data = 32'h7000; bus.lr_valid = 2'b11; #1;
    chk("post_rst_hold", {63'd0, bus.wb_hold}, 64'd0);
    chk("post_rst_rdy", {62'd0, bus.lr_rdy}, 64'd0);
    push(5'd25, 32'h7000);
    @(negedge clk);
    chk("post_rst_gpr_wr", {63'd0, bus.gpr_wr}, 64'd0);
    chk("post_rst_gpr_addr", {59'd0, bus.gpr_addr}, 64'd0);
    chk("post_rst_gpr_data", {32'd0, bus.gpr_data}, 64'd0);
    for (int i = 1; i < 4; i++) begin
      tick(); bus.wb_addr = 5'(25 + i); bus.wb_data = 32'h7000 + i; #1;
      chk("post_rst_cnt_hold", {63'd0, bus.wb_hold}, 64'd0);
      push(5'(25 + i), 32'h7000 + i);
    end
    tick(); #1;
    chk("post_rst_hold_on", {63'd0, bus.wb_hold}, 64'd1);
    chk("post_rst_ptr_gnt", {62'd0, bus.lr_rdy}, 64'd1);
    push(5'd12, 32'hC0);
    tick(); bus.wb_wr = 1'b0; bus.lr_valid = 2'b00; #1;
    chk("post_rst_hold_off", {63'd0, bus.wb_hold}, 64'd0);

    repeat (3) tick();
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
